booth_mult_param: RTL and testbench
===================================

BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to begin one multiplication.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand M.
REQ-007 SHALL have port multiplier  input  WIDTH  operand Q.
REQ-008 SHALL have port ready  output  1  high when a start will be accepted.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when product is valid.
REQ-011 SHALL have port product  output  2*WIDTH  result; signed or unsigned per the captured mode.

Function
REQ-012 SHALL implement a radix-2 Booth algorithm with FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, ready=1, busy=0 and done=0.
REQ-014 In IDLE with start=1 at a rising edge (accept edge E0), the block SHALL do all of the following at once: capture multiplicand, multiplier and signed_mode; clear accumulator A and the Q[-1] bit; load the iteration counter with N; enter RUN.
REQ-015 The iteration count N SHALL be WIDTH when signed_mode=1 and WIDTH+1 when signed_mode=0.
REQ-016 When signed_mode=0, the block SHALL zero-extend both operands to WIDTH+1 bits internally.
REQ-017 When signed_mode=1, the block SHALL sign-extend both operands to WIDTH+1 bits internally.
REQ-018 A and M SHALL be WIDTH+1 bits wide internally.
REQ-019 Each RUN edge SHALL perform one iteration in a single cycle, selected by {Q[0],Q[-1]}:
- 01: A + M
- 10: A - M
- 00 or 11: no change
The result SHALL then be arithmetic-right-shifted one place across {A,Q,Q[-1]}, and the counter decremented.
REQ-020 Add and subtract SHALL use modulo-2^(WIDTH+1) arithmetic; intermediate overflow is not flagged.
REQ-021 After the N-th RUN edge (edge E0+N), the block SHALL enter DONE, drive done=1 and update product with the low 2*WIDTH bits of {A,Q}.
REQ-022 The edge after DONE SHALL return the FSM to IDLE unconditionally.
REQ-023 Latency from the accept edge to done high SHALL be exactly N cycles; done SHALL be high for exactly one cycle.
REQ-024 busy SHALL be 1 in RUN and DONE; ready SHALL be 0 in RUN and DONE.
REQ-025 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-026 Operand and mode input changes after E0 SHALL NOT affect the running operation.
REQ-027 product SHALL hold its last value until the next DONE entry; it SHALL NOT change during RUN.
REQ-028 Back-to-back operation: start held high continuously SHALL be accepted on the first IDLE edge after each DONE, giving a throughput of one result per N+2 cycles.
REQ-029 Unused or illegal FSM encodings SHALL return to IDLE on the next edge.
REQ-030 All outputs SHALL be driven from registers or decoded from state only, with no combinational path from the inputs.

Reset
REQ-031 rst_n=0 SHALL, asynchronously and regardless of clock, force all of the following: state IDLE, product=0, A=0, Q=0, Q[-1]=0, counter=0, done=0, busy=0, ready=1.
REQ-032 Reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and clear product to 0.
REQ-033 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-034 WIDTH=8, signed_mode=1, M=-128, Q=-128, start pulse -> done high exactly 8 cycles after the accept edge, product=16'h4000, busy=1 for 9 cycles.
REQ-035 WIDTH=8, signed_mode=0, M=255, Q=255 -> done exactly 9 cycles after the accept edge, product=16'hFE01; repeat with signed_mode=1 (M=-1, Q=-1) -> product=16'h0001.
REQ-036 WIDTH=8, signed_mode=1: (M=-1, Q=1) -> 16'hFFFF; (M=0, Q=-77) -> 16'h0000; (M=127, Q=-128) -> 16'hC080.
REQ-037 Start held high with new operands presented mid-RUN -> current result unaffected, second operation accepted only at the IDLE edge, two done pulses spaced 10 cycles apart (signed, WIDTH=8).
REQ-038 rst_n pulsed low 3 cycles into RUN -> outputs cleared immediately without a clock edge, no done pulse, ready=1; a subsequent 5*-3 (signed) -> product=16'hFFF1.
REQ-039 WIDTH=16 and WIDTH=2 exhaustive or random signed and unsigned checks against a reference product, plus an assertion that done is never high for two consecutive cycles.

Source files
------------

// File: rtl/booth_mult_param.sv
// ----------------------------------------------------------------------------
// booth_mult_param
// Sequential radix-2 Booth multiplier that retires one iteration per clock.
// Operands are widened by one bit so that a single datapath handles both
// two's-complement and unsigned operands:
//   - signed mode sign-extends the operands and runs WIDTH iterations.
//   - unsigned mode zero-extends the operands and runs WIDTH+1 iterations.
// The partial product lives in {A, Q, Q[-1]}. After the final iteration the
// product is copied into a holding register, and done pulses for one cycle.
// ----------------------------------------------------------------------------
module booth_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Internal operand and accumulator width (one guard bit).
    localparam int XW = WIDTH + 1;
    // The counter must be able to hold WIDTH+1 iterations.
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Widen an operand to XW bits. Sign-extend only in signed mode.
    function automatic logic [XW-1:0] widen(input logic [WIDTH-1:0] val,
                                            input logic             sgn);
        return {sgn & val[WIDTH-1], val};
    endfunction

    // Pick the product bits out of the final {A, Q} register.
    // Signed mode runs one iteration fewer than unsigned mode. Because of
    // that, the top multiplier bit (the sign copy) is still in Q[0], and the
    // product sits one place higher than in unsigned mode.
    function automatic logic [2*WIDTH-1:0] align_product(input logic [XW-1:0] acc,
                                                         input logic [XW-1:0] mq,
                                                         input logic          sgn);
        logic [2*WIDTH-1:0] res;
        if (sgn) begin
            res = {acc[WIDTH-1:0], mq[XW-1:1]};
        end else begin
            res = {acc[WIDTH-2:0], mq};
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [XW-1:0]      a_q, a_d;
    logic [XW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [XW-1:0]      m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [XW-1:0]      sum_s;
    logic [XW-1:0]      sh_a_s;
    logic [XW-1:0]      sh_q_s;
    logic               sh_qm1_s;

    // Booth step: add/subtract M based on {Q[0],Q[-1]}, then shift arithmetically.
    always_comb begin
        sum_s = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum_s = a_q + m_q;
            2'b10:   sum_s = a_q - m_q;
            default: sum_s = a_q;
        endcase
        {sh_a_s, sh_q_s, sh_qm1_s} = {sum_s[XW-1], sum_s, q_q};
    end

    // Next-state and datapath load/update decisions.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = widen(multiplicand, signed_mode);
                    q_d     = widen(multiplier, signed_mode);
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    mode_d  = signed_mode;
                    cnt_d   = signed_mode ? CW'(WIDTH) : CW'(WIDTH + 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = sh_a_s;
                q_d   = sh_q_s;
                qm1_d = sh_qm1_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = ST_DONE;
                    product_d = align_product(sh_a_s, sh_q_s, mode_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset clears everything, including the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_q == q_d ? q_q : q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            product_q <= product_d;
        end
    end

    // Handshake outputs are decoded from the state register only.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_param.sv
// ----------------------------------------------------------------------------
// Testbench for booth_mult_param. It instantiates the design at WIDTH = 8,
// 16 and 2. Every task pushes the expected products from a reference model
// onto a scoreboard queue when it drives the stimulus. The task pops them
// again when done is seen and compares them inline.
// ----------------------------------------------------------------------------
module tb_booth_mult_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sm_in;
    logic [15:0] m_in;
    logic [15:0] q_in;
    logic        st8, st16, st2;

    logic        rdy8, bsy8, dn8;
    logic [15:0] p8;
    logic        rdy16, bsy16, dn16;
    logic [31:0] p16;
    logic        rdy2, bsy2, dn2;
    logic [3:0]  p2;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          dbl_cnt   = 0;
    logic        pd8  = 1'b0;
    logic        pd16 = 1'b0;
    logic        pd2  = 1'b0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    booth_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm_in),
        .multiplicand(m_in[7:0]), .multiplier(q_in[7:0]),
        .ready(rdy8), .busy(bsy8), .done(dn8), .product(p8)
    );

    booth_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm_in),
        .multiplicand(m_in), .multiplier(q_in),
        .ready(rdy16), .busy(bsy16), .done(dn16), .product(p16)
    );

    booth_mult_param #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .signed_mode(sm_in),
        .multiplicand(m_in[1:0]), .multiplier(q_in[1:0]),
        .ready(rdy2), .busy(bsy2), .done(dn2), .product(p2)
    );

    // Count any cycle where done is high two cycles in a row on any instance.
    always @(negedge clk) begin
        if ((dn8 && pd8) || (dn16 && pd16) || (dn2 && pd2)) begin
            dbl_cnt <= dbl_cnt + 1;
        end
        pd8  <= dn8;
        pd16 <= dn16;
        pd2  <= dn2;
    end

    // Reference product built from w-bit operands extended to 64 bits.
    function automatic logic [31:0] ref_prod(input int w, input logic sm,
                                             input logic [15:0] m, input logic [15:0] q);
        logic signed [63:0] ma, qa, pr;
        logic [63:0]        mk;
        ma = '0;
        qa = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                ma[i] = m[i];
                qa[i] = q[i];
            end else begin
                ma[i] = sm & m[w-1];
                qa[i] = sm & q[w-1];
            end
        end
        pr = ma * qa;
        mk = (64'd1 << (2 * w)) - 64'd1;
        return 32'(pr & mk);
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? dn8 : (w == 16) ? dn16 : dn2;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? bsy8 : (w == 16) ? bsy16 : bsy2;
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        return (w == 8) ? {16'h0000, p8} : (w == 16) ? p16 : {28'h0000000, p2};
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 8) st8 = v;
        else if (w == 16) st16 = v;
        else st2 = v;
    endtask

    // Start one operation with a one-cycle start pulse. Measure the latency
    // from the accept edge to done, the product seen with done, and the
    // number of cycles busy is high.
    task automatic run_op(input int w, input logic sm, input logic [15:0] m,
                          input logic [15:0] q, output int lat,
                          output logic [31:0] prod, output int bcnt);
        lat  = -1;
        bcnt = 0;
        prod = '0;
        @(negedge clk);
        sm_in = sm;
        m_in  = m;
        q_in  = q;
        set_start(w, 1'b1);
        sb.push_back(ref_prod(w, sm, m, q));
        @(posedge clk);
        #1;
        if (get_busy(w)) bcnt++;
        @(negedge clk);
        set_start(w, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (get_busy(w)) bcnt++;
            if (get_done(w) && lat < 0) begin
                lat  = c;
                prod = get_prod(w);
            end
            if (!get_busy(w)) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt += 4;
        if (rdy8 !== 1'b1) $display("FAIL reset_ready got %b exp 1", rdy8); else pass_cnt++;
        if (bsy8 !== 1'b0) $display("FAIL reset_busy got %b exp 0", bsy8); else pass_cnt++;
        if (dn8 !== 1'b0) $display("FAIL reset_done got %b exp 0", dn8); else pass_cnt++;
        if (p8 !== 16'h0000) $display("FAIL reset_product got %h exp 0000", p8); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_corner_signed();
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        run_op(8, 1'b1, 16'h0080, 16'h0080, lat, prod, bcnt);
        exp_v = sb.pop_front();
        total_cnt += 4;
        if (lat !== 8) $display("FAIL corner_latency got %0d exp 8", lat); else pass_cnt++;
        if (bcnt !== 9) $display("FAIL corner_busy_cycles got %0d exp 9", bcnt); else pass_cnt++;
        if (prod !== 32'h00004000) $display("FAIL corner_product got %h exp 00004000", prod); else pass_cnt++;
        if (prod !== exp_v) $display("FAIL corner_scoreboard got %h exp %h", prod, exp_v); else pass_cnt++;
    endtask

    task automatic test_unsigned_max();
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        run_op(8, 1'b0, 16'h00FF, 16'h00FF, lat, prod, bcnt);
        exp_v = sb.pop_front();
        total_cnt += 3;
        if (lat !== 9) $display("FAIL umax_latency got %0d exp 9", lat); else pass_cnt++;
        if (prod !== 32'h0000FE01) $display("FAIL umax_product got %h exp 0000fe01", prod); else pass_cnt++;
        if (prod !== exp_v) $display("FAIL umax_scoreboard got %h exp %h", prod, exp_v); else pass_cnt++;
        run_op(8, 1'b1, 16'h00FF, 16'h00FF, lat, prod, bcnt);
        exp_v = sb.pop_front();
        total_cnt += 3;
        if (lat !== 8) $display("FAIL sneg1_latency got %0d exp 8", lat); else pass_cnt++;
        if (prod !== 32'h00000001) $display("FAIL sneg1_product got %h exp 00000001", prod); else pass_cnt++;
        if (prod !== exp_v) $display("FAIL sneg1_scoreboard got %h exp %h", prod, exp_v); else pass_cnt++;
    endtask

    task automatic test_signed_mix();
        logic [15:0] mv[3] = '{16'h00FF, 16'h0000, 16'h007F};
        logic [15:0] qv[3] = '{16'h0001, 16'h00B3, 16'h0080};
        logic [31:0] ev[3] = '{32'h0000FFFF, 32'h00000000, 32'h0000C080};
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        for (int k = 0; k < 3; k++) begin
            run_op(8, 1'b1, mv[k], qv[k], lat, prod, bcnt);
            exp_v = sb.pop_front();
            total_cnt += 2;
            if (prod !== ev[k]) $display("FAIL mix%0d_product got %h exp %h", k, prod, ev[k]); else pass_cnt++;
            if (prod !== exp_v) $display("FAIL mix%0d_scoreboard got %h exp %h", k, prod, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [15:0] r1, r2, mid;
        logic [31:0] e1, e2;
        d1  = -1;
        d2  = -1;
        r1  = '0;
        r2  = '0;
        mid = '0;
        @(negedge clk);
        sm_in = 1'b1;
        m_in  = 16'h0064;   // 100
        q_in  = 16'h00FD;   // -3
        st8   = 1'b1;
        sb.push_back(ref_prod(8, 1'b1, 16'h0064, 16'h00FD));
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                m_in = 16'h00CE;    // -50
                q_in = 16'h0007;    // 7
                sb.push_back(ref_prod(8, 1'b1, 16'h00CE, 16'h0007));
            end
            if (c == 13) mid = p8;
            if (dn8) begin
                if (d1 < 0) begin
                    d1 = c;
                    r1 = p8;
                end else if (d2 < 0) begin
                    d2  = c;
                    r2  = p8;
                    st8 = 1'b0;
                end
            end
            if (d2 >= 0 && !bsy8) break;
        end
        st8 = 1'b0;
        e1 = sb.pop_front();
        e2 = sb.pop_front();
        total_cnt += 7;
        if (d1 !== 8) $display("FAIL b2b_first_latency got %0d exp 8", d1); else pass_cnt++;
        if (r1 !== 16'hFED4) $display("FAIL b2b_first_product got %h exp fed4", r1); else pass_cnt++;
        if ({16'h0000, r1} !== e1) $display("FAIL b2b_first_scoreboard got %h exp %h", r1, e1); else pass_cnt++;
        if (d2 - d1 !== 10) $display("FAIL b2b_spacing got %0d exp 10", d2 - d1); else pass_cnt++;
        if (r2 !== 16'hFEA2) $display("FAIL b2b_second_product got %h exp fea2", r2); else pass_cnt++;
        if ({16'h0000, r2} !== e2) $display("FAIL b2b_second_scoreboard got %h exp %h", r2, e2); else pass_cnt++;
        if (mid !== 16'hFED4) $display("FAIL b2b_hold_during_run got %h exp fed4", mid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic saw;
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        saw = 1'b0;
        @(negedge clk);
        sm_in = 1'b1;
        m_in  = 16'h0005;
        q_in  = 16'h0007;
        st8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt += 4;
        if (rdy8 !== 1'b1) $display("FAIL abort_ready got %b exp 1", rdy8); else pass_cnt++;
        if (bsy8 !== 1'b0) $display("FAIL abort_busy got %b exp 0", bsy8); else pass_cnt++;
        if (dn8 !== 1'b0) $display("FAIL abort_done got %b exp 0", dn8); else pass_cnt++;
        if (p8 !== 16'h0000) $display("FAIL abort_product got %h exp 0000", p8); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (dn8) saw = 1'b1;
        end
        total_cnt += 1;
        if (saw !== 1'b0) $display("FAIL abort_no_done got %b exp 0", saw); else pass_cnt++;
        run_op(8, 1'b1, 16'h0005, 16'h00FD, lat, prod, bcnt);
        exp_v = sb.pop_front();
        total_cnt += 3;
        if (lat !== 8) $display("FAIL post_reset_latency got %0d exp 8", lat); else pass_cnt++;
        if (prod !== 32'h0000FFF1) $display("FAIL post_reset_product got %h exp 0000fff1", prod); else pass_cnt++;
        if (prod !== exp_v) $display("FAIL post_reset_scoreboard got %h exp %h", prod, exp_v); else pass_cnt++;
    endtask

    task automatic test_w2_exhaustive();
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 4; m++) begin
                for (int q = 0; q < 4; q++) begin
                    run_op(2, s[0], 16'(m), 16'(q), lat, prod, bcnt);
                    exp_v = sb.pop_front();
                    total_cnt += 2;
                    if (prod !== exp_v)
                        $display("FAIL w2_product s=%0d m=%0d q=%0d got %h exp %h", s, m, q, prod, exp_v);
                    else pass_cnt++;
                    if (lat !== (s == 1 ? 2 : 3))
                        $display("FAIL w2_latency s=%0d got %0d exp %0d", s, lat, (s == 1 ? 2 : 3));
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_w16_random();
        int lat, bcnt;
        logic [31:0] prod, exp_v;
        logic [15:0] m, q;
        logic        sm;
        for (int i = 0; i < 24; i++) begin
            sm = i[0];
            m  = 16'($urandom);
            q  = 16'($urandom);
            if (i == 0) begin m = 16'hFFFF; q = 16'hFFFF; end
            if (i == 1) begin m = 16'h8000; q = 16'h8000; end
            if (i == 3) begin m = 16'h7FFF; q = 16'h8000; end
            run_op(16, sm, m, q, lat, prod, bcnt);
            exp_v = sb.pop_front();
            total_cnt += 2;
            if (prod !== exp_v)
                $display("FAIL w16_product s=%0d m=%h q=%h got %h exp %h", sm, m, q, prod, exp_v);
            else pass_cnt++;
            if (lat !== (sm ? 16 : 17))
                $display("FAIL w16_latency s=%0d got %0d exp %0d", sm, lat, (sm ? 16 : 17));
            else pass_cnt++;
        end
    endtask

    task automatic test_done_pulse();
        total_cnt += 1;
        if (dbl_cnt !== 0) $display("FAIL done_single_cycle got %0d exp 0", dbl_cnt); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        st8   = 1'b0;
        st16  = 1'b0;
        st2   = 1'b0;
        sm_in = 1'b0;
        m_in  = '0;
        q_in  = '0;
        test_reset();
        test_corner_signed();
        test_unsigned_max();
        test_signed_mix();
        test_back_to_back();
        test_reset_mid_run();
        test_w2_exhaustive();
        test_w16_random();
        test_done_pulse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
